// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path constants and the fetch FSM state type.
// Holds the PC/instruction widths, reset PC, NOP encoding and enable levels.
package inst_fetch_pkg;

  localparam int unsigned               PC_LENGTH    = 32;
  localparam int unsigned               INST_LEN     = 32;
  localparam logic [PC_LENGTH-1:0]      RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_LEN-1:0]       INST_NOP     = 32'h0000_0000;
  localparam logic                      ENABLE       = 1'b1;
  localparam logic                      DISABLE      = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO of {pc,inst} words; clear has priority over push.
// Head entry is presented from registered storage; count feeds the credit check.
module inst_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != FULL_CNT) || do_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  always_comb begin
    dout = mem[rd_ptr];
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency InstMem reads,
// buffers returned words and hands them to ID over a valid/ready handshake.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned           INST_LENGTH = INST_LEN,
  parameter int unsigned           ADDR_WIDTH  = PC_LENGTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int unsigned           FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_ce,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INST_LENGTH-1:0] imem_rdata,
  output logic [INST_LENGTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0]  inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  flush_pc
);

  localparam int unsigned FW = ADDR_WIDTH + INST_LENGTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  credit_ok;
  logic [CW-1:0]         count;
  logic [FW-1:0]         head;
  logic [CW:0]           used;
  logic [CW:0]           limit;

  inst_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({addr_q, imem_rdata}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  // Credit check written as used < depth + pop to avoid an unsigned underflow.
  always_comb begin
    pop       = inst_valid && inst_ready;
    push      = inflight && !flush;
    used      = {1'b0, count} + (CW+1)'(inflight);
    limit     = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
    credit_ok = used < limit;
  end

  always_comb begin
    state_nxt = state;
    issue     = DISABLE;
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN:  issue     = !flush && credit_ok;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = RUN;
  end

  always_comb begin
    imem_ce   = issue;
    imem_addr = issue ? pc : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      addr_q   <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        pc       <= flush_pc & ~ADDR_WIDTH'(3);
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          pc     <= pc + ADDR_WIDTH'(4);
          addr_q <= pc;
        end
      end
    end
  end

  always_comb begin
    inst_valid = (count != '0);
    inst       = inst_valid ? head[INST_LENGTH-1:0] : INST_LENGTH'(INST_NOP);
    inst_pc    = inst_valid ? head[FW-1:INST_LENGTH] : '0;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end: the producer side of the instruction word consumed by the ID decoder.
- Owns the PC and issues word reads to InstMem, which has a fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents them, tagged with their PC, over a valid/ready handshake.
- Accepts a redirect (flush) from branch/jump resolution.

Parameters:
- INST_LENGTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / InstMem byte-address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst==0 resets).
- imem_ce  out  1  InstMem read enable.
- imem_addr  out  ADDR_WIDTH  InstMem byte address, always word-aligned.
- imem_rdata  in  INST_LENGTH  InstMem data; valid the cycle after imem_ce.
- inst  out  INST_LENGTH  instruction to ID; 32'h0 (NOP) when inst_valid==0.
- inst_pc  out  ADDR_WIDTH  PC of inst; 0 when inst_valid==0.
- inst_valid  out  1  inst/inst_pc hold a fetched instruction.
- inst_ready  in  1  ID accepts; transfer occurs when inst_valid && inst_ready.
- flush  in  1  redirect request: discard all buffered and in-flight words.
- flush_pc  in  ADDR_WIDTH  redirect target; bits[1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst==0, async) values:
  - pc=RESET_PC, state=IDLE.
  - imem_ce=0, imem_addr=0.
  - FIFO empty, inflight=0.
  - inst_valid=0, inst=0, inst_pc=0.
- FSM states:
  - IDLE: one cycle after reset release, no request issued; always goes to RUN.
  - RUN: normal fetch.
- Issue rule (RUN, flush==0):
  - imem_ce=1 and imem_addr=pc when occupancy + inflight − pop < FIFO_DEPTH, where pop = inst_valid && inst_ready.
  - On issue, pc <= pc+4, wrapping modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 0).
- imem_ce/imem_addr are combinational from registered state and inputs. When imem_ce==0, imem_addr=0.
- Return path:
  - inflight is a 1-bit register = "issued last cycle".
  - When inflight==1, imem_rdata is written into the FIFO at the end of that cycle together with its PC (held in a registered addr_q).
- Output timing:
  - inst/inst_pc/inst_valid reflect the FIFO head (registered storage).
  - Latency from issue to inst_valid is 2 cycles.
  - Sustained throughput is 1 instr/cycle while inst_ready==1.
- Backpressure:
  - inst_ready==0 holds the head stable; inst, inst_pc and inst_valid must not change.
  - Issue stops once credits are exhausted, so the FIFO never overflows.
- Flush (highest priority, RUN or IDLE):
  - In the flush cycle, imem_ce=0.
  - At the clock edge: FIFO cleared, inflight cleared, pc <= {flush_pc[ADDR_WIDTH-1:2],2'b00}.
  - A word returning in the flush cycle is dropped.
  - A pop in the flush cycle is still a valid transfer to ID; ID discards it by its own flush.
  - The first fetch at the new target is issued the cycle after flush (state=RUN).
- Back-to-back flushes: the last one wins; there are no fetches between them.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Reset mid-operation: all state returns immediately to reset values; in-flight data is discarded.

Decomposition:
- Shared header MIPS.vh gets:
  - `PC_LENGTH
  - `RESET_PC
  - `INST_NOP (32'h0)
  - reuse of `INST_LENGTH, `ENABLE/`DISABLE
- Sub-module: inst_fifo, a synchronous FIFO of {pc,inst} with push/pop/clear.
  - clear has priority over push; count output used for the credit check.
  - Same clk/rst conventions.

Test Plan:
- Reset release, inst_ready=1, memory returns word = address:
  - imem_ce first high 1 cycle after release with addr 0.
  - inst_valid high 2 cycles later, with inst=0/pc=0, then 4, 8, … on consecutive cycles.
- Steady stream, then inst_ready=0 for 5 cycles:
  - at most FIFO_DEPTH words buffered; imem_ce drops.
  - inst/inst_pc frozen.
  - on ready, consecutive PCs resume with no loss or duplication.
- Flush with flush_pc=32'h0000_0103 while FIFO holds 2 entries and 1 in flight:
  - next cycle inst_valid=0, imem_ce=1 with addr 0x100.
  - first delivered instruction has inst_pc=0x100.
- Flush asserted in two consecutive cycles (0x200 then 0x300):
  - no request to 0x200.
  - next fetch is 0x300.
- Redirect to 32'hFFFF_FFF8, stream 3 words:
  - PCs delivered FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst pulsed low mid-stream (async, between edges):
  - outputs immediately 0.
  - after release, fetch restarts at RESET_PC per the reset-release scenario.
